// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a small programmable table of
// {frequency, waveform select, duration} entries and drives the CORDIC
// frequency/waveform inputs plus a tone enable for the PWM stage.
// Durations count in ticks of TICK_DIV clocks; an optional muted gap
// separates steps and the sequence may loop back to entry 0.
module tone_sequencer #(
  parameter int freq_width = 12,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int DUR_WIDTH  = 16,
  parameter int TICK_DIV   = 131072,
  parameter int GAP_TICKS  = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [freq_width-1:0] wr_freq,
  input  logic                  wr_sel,
  input  logic [DUR_WIDTH-1:0]  wr_dur,
  input  logic [ADDR_W-1:0]     last_addr,
  input  logic                  loop,
  input  logic                  start,
  input  logic                  stop,
  output logic [freq_width-1:0] freq,
  output logic                  waveform_sel,
  output logic                  tone_en,
  output logic                  busy,
  output logic [ADDR_W-1:0]     step,
  output logic                  done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [freq_width-1:0]   r_tf [DEPTH];
  logic                    r_ts [DEPTH];
  logic [DUR_WIDTH-1:0]    r_td [DEPTH];
  logic [freq_width-1:0]   r_freq, w_freq_nxt;
  logic                    r_sel, w_sel_nxt;
  logic [ADDR_W-1:0]       r_step, w_step_nxt;
  logic                    r_done, w_done_nxt;
  logic [PW-1:0]           r_presc, w_presc_nxt;
  logic [DUR_WIDTH-1:0]    r_dur, w_dur_nxt;
  logic                    w_tick, w_adv, w_byp;
  logic [freq_width-1:0]   w_rd_freq;
  logic                    w_rd_sel;
  logic [DUR_WIDTH-1:0]    w_rd_dur;

  // Table read with write bypass so a write landing in the FETCH cycle is seen
  assign w_byp     = wr_en && (wr_addr == r_step);
  assign w_rd_freq = w_byp ? wr_freq : r_tf[r_step];
  assign w_rd_sel  = w_byp ? wr_sel  : r_ts[r_step];
  assign w_rd_dur  = w_byp ? wr_dur  : r_td[r_step];
  assign w_tick    = (r_presc == PRESC_MAX);

  // Step table storage; writes accepted in any state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tf[i] <= '0;
        r_ts[i] <= 1'b0;
        r_td[i] <= '0;
      end
    end else if (wr_en) begin
      r_tf[wr_addr] <= wr_freq;
      r_ts[wr_addr] <= wr_sel;
      r_td[wr_addr] <= wr_dur;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_freq  <= '0;
      r_sel   <= 1'b0;
      r_step  <= '0;
      r_done  <= 1'b0;
      r_presc <= '0;
      r_dur   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_freq  <= w_freq_nxt;
      r_sel   <= w_sel_nxt;
      r_step  <= w_step_nxt;
      r_done  <= w_done_nxt;
      r_presc <= w_presc_nxt;
      r_dur   <= w_dur_nxt;
    end
  end

  // Next-state logic; stop overrides everything and leaves freq/sel/step held
  always_comb begin
    w_state_nxt = r_state;
    w_freq_nxt  = r_freq;
    w_sel_nxt   = r_sel;
    w_step_nxt  = r_step;
    w_done_nxt  = 1'b0;
    w_presc_nxt = r_presc;
    w_dur_nxt   = r_dur;
    w_adv       = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_step_nxt  = '0;
            w_state_nxt = FETCH;
          end
        end
        FETCH: begin
          if (w_rd_dur == '0) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_freq_nxt  = w_rd_freq;
            w_sel_nxt   = w_rd_sel;
            w_dur_nxt   = w_rd_dur;
            w_presc_nxt = '0;
            w_state_nxt = PLAY;
          end
        end
        PLAY, GAP: begin
          w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
          if (w_tick) begin
            w_dur_nxt = r_dur - DUR_WIDTH'(1);
            if (r_dur == DUR_WIDTH'(1)) begin
              if (r_state == PLAY && GAP_TICKS > 0) begin
                w_dur_nxt   = DUR_WIDTH'(GAP_TICKS);
                w_state_nxt = GAP;
              end else begin
                w_adv = 1'b1;
              end
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      // Advance: next entry, wrap to 0 when looping, else finish
      if (w_adv) begin
        if (r_step != last_addr) begin
          w_step_nxt  = r_step + ADDR_W'(1);
          w_state_nxt = FETCH;
        end else if (loop) begin
          w_step_nxt  = '0;
          w_state_nxt = FETCH;
        end else begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    end
  end

  assign freq         = r_freq;
  assign waveform_sel = r_sel;
  assign tone_en      = (r_state == PLAY);
  assign busy         = (r_state != IDLE);
  assign step         = r_step;
  assign done         = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: a per-cycle expected trace is generated from the
// sequencing rules (fetch, dur*TD play cycles, GT*TD gap cycles, advance)
// and compared against the DUT outputs every cycle.
module tb_tone_sequencer;
  localparam int TD = 4;
  localparam int GT = 1;

  logic        clock = 0, resetn = 0, wr_en = 0, wr_sel = 0, loop = 0, start = 0, stop = 0;
  logic [2:0]  wr_addr = 0, last_addr = 0;
  logic [11:0] wr_freq = 0;
  logic [15:0] wr_dur = 0;
  logic [11:0] freq;
  logic        waveform_sel, tone_en, busy, done;
  logic [2:0]  step;

  tone_sequencer #(.freq_width(12), .DEPTH(8), .ADDR_W(3), .DUR_WIDTH(16),
                   .TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_freq(wr_freq), .wr_sel(wr_sel), .wr_dur(wr_dur), .last_addr(last_addr),
    .loop(loop), .start(start), .stop(stop), .freq(freq),
    .waveform_sel(waveform_sel), .tone_en(tone_en), .busy(busy), .step(step),
    .done(done));

  always #5 clock = ~clock;

  typedef struct packed {
    logic tone; logic busy; logic done; logic [2:0] step; logic [11:0] freq; logic sel;
  } exp_t;

  int          n_asrt = 0, n_fail = 0;
  logic [11:0] tf [8];
  logic        ts [8];
  logic [15:0] td [8];
  logic [11:0] mf;
  logic        ms;
  logic [2:0]  m_step;
  exp_t        q [$];

  function automatic exp_t mk(logic [2:0] tbd, logic [2:0] s, logic [11:0] f, logic sl);
    return exp_t'({tbd, s, f, sl});
  endfunction

  task automatic chk(string tag, exp_t e);
    exp_t o;
    o = {tone_en, busy, done, step, freq, waveform_sel};
    n_asrt++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed tone/busy/done=%b%b%b step=%0d freq=%0d sel=%b, expected %b%b%b step=%0d freq=%0d sel=%b",
             tag, o.tone, o.busy, o.done, o.step, o.freq, o.sel,
             e.tone, e.busy, e.done, e.step, e.freq, e.sel);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin tf[i] = 0; ts[i] = 0; td[i] = 0; end
    mf = 0; ms = 0; m_step = 0;
  endtask

  task automatic wr(logic [2:0] a, logic [11:0] f, logic s, logic [15:0] d);
    wr_en = 1; wr_addr = a; wr_freq = f; wr_sel = s; wr_dur = d;
    @(negedge clock);
    wr_en = 0;
    tf[a] = f; ts[a] = s; td[a] = d;
  endtask

  // Reference trace from start acceptance; a write at cycle wcyc is visible
  // to any FETCH at or after that cycle.
  task automatic build(int cap, int wcyc, logic [2:0] wa, logic [11:0] wf, logic ws, logic [15:0] wd);
    logic [2:0] s = 0;
    bit fin = 0;
    bit applied = (wcyc < 0);
    q.delete();
    while (!fin && q.size() < cap) begin
      if (!applied && q.size() >= wcyc) begin
        tf[wa] = wf; ts[wa] = ws; td[wa] = wd; applied = 1;
      end
      q.push_back(mk(3'b010, s, mf, ms));
      if (td[s] == 0) begin
        q.push_back(mk(3'b001, s, mf, ms)); fin = 1;
      end else begin
        mf = tf[s]; ms = ts[s];
        repeat (int'(td[s]) * TD) q.push_back(mk(3'b110, s, mf, ms));
        repeat (GT * TD) q.push_back(mk(3'b010, s, mf, ms));
        if (s != last_addr) s++;
        else if (loop) s = 0;
        else begin q.push_back(mk(3'b001, s, mf, ms)); fin = 1; end
      end
    end
    if (fin) q.push_back(mk(3'b000, s, mf, ms));
    if (!applied) begin tf[wa] = wf; ts[wa] = ws; td[wa] = wd; end
    m_step = s;
  endtask

  // kind: 0 none, 1 start pulse, 2 stop pulse, 3 async reset (at poke_at)
  task automatic play(string tag, int cap, int wcyc, logic [2:0] wa, logic [11:0] wf,
                      logic ws, logic [15:0] wd, int poke_at, int kind);
    int   stopped = 0;
    exp_t se;
    build(cap, wcyc, wa, wf, ws, wd);
    start = 1;
    @(negedge clock);
    start = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (stopped > 0) begin
        chk(tag, se);
        stopped++;
        if (stopped > 3) break;
      end else chk(tag, q[i]);
      wr_en = (i == wcyc);
      if (i == wcyc) begin wr_addr = wa; wr_freq = wf; wr_sel = ws; wr_dur = wd; end
      start = (kind == 1 && i == poke_at && i < q.size() - 2);
      stop  = (kind == 2 && i == poke_at && stopped == 0);
      if (stop) begin
        se = q[i]; se.tone = 0; se.busy = 0; se.done = 0;
        mf = se.freq; ms = se.sel; m_step = se.step; stopped = 1;
      end
      if (kind == 3 && i == poke_at) begin
        #1 resetn = 0;
        #1 chk({tag, "_async"}, mk(3'b000, 3'd0, 12'd0, 1'b0));
        return;
      end
      @(negedge clock);
    end
    wr_en = 0; start = 0; stop = 0;
  endtask

  initial begin
    clear_model();
    repeat (2) @(negedge clock);
    chk("reset", mk(3'b000, 3'd0, 12'd0, 1'b0));
    resetn = 1;
    @(negedge clock);
    chk("idle_after_reset", mk(3'b000, 3'd0, 12'd0, 1'b0));

    // Basic single pass
    wr(0, 100, 1, 2); wr(1, 200, 0, 1); wr(2, 300, 1, 3);
    last_addr = 2; loop = 0;
    play("basic", 300, -1, 0, 0, 0, 0, -1, 0);

    // Loop back to step 0, then abort mid-PLAY
    loop = 1;
    play("loop_stop", 60, -1, 0, 0, 0, 0, 45, 2);

    // start and stop together from IDLE
    start = 1; stop = 1;
    @(negedge clock);
    start = 0; stop = 0;
    chk("start_stop_idle", mk(3'b000, m_step, mf, ms));
    @(negedge clock);
    chk("start_stop_idle2", mk(3'b000, m_step, mf, ms));

    // start during PLAY is ignored
    loop = 0;
    play("start_in_play", 300, -1, 0, 0, 0, 0, 5, 1);

    // Write to step 1 during its FETCH is bypassed into PLAY
    play("bypass", 300, 13, 1, 555, 0, 1, -1, 0);

    // Write to step 0 during its PLAY shows only at the next loop FETCH
    loop = 1;
    play("wr_in_play", 50, 3, 0, 777, 0, 2, 45, 2);

    // End marker at entry 1
    loop = 0;
    wr(1, 200, 0, 0);
    play("end_marker", 300, -1, 0, 0, 0, 0, -1, 0);

    // Asynchronous reset during PLAY
    wr(1, 200, 0, 1);
    play("areset", 300, -1, 0, 0, 0, 0, 4, 3);
    @(negedge clock);
    clear_model();
    chk("areset_hold", mk(3'b000, 3'd0, 12'd0, 1'b0));
    resetn = 1;
    @(negedge clock);
    chk("areset_idle", mk(3'b000, 3'd0, 12'd0, 1'b0));
    play("post_reset", 50, -1, 0, 0, 0, 0, -1, 0);

    // Randomized tables
    for (int r = 0; r < 10; r++) begin
      int pk;
      for (int a = 0; a < 8; a++)
        wr(3'(a), 12'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 3)));
      last_addr = 3'($urandom_range(0, 7));
      loop = 1'($urandom_range(0, 1));
      pk = $urandom_range(3, 120);
      if (loop) play("rand_loop", pk + 5, -1, 0, 0, 0, 0, pk, 2);
      else      play("rand_pass", 400, -1, 0, 0, 0, 0, pk, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Scheduler that drives the freq and waveform_sel inputs of the CORDIC/PWM tone path from a small programmable step table.
- Each step holds a frequency word, a sine/cosine select and a duration.
- Plays steps in order, with an optional muted gap between steps and optional looping.
- Sits between the board control logic and the CORDIC/PWM wrapper; tone_en gates the PWM output.

Parameters:
freq_width, 12, width of the frequency word (matches CORDIC freq input)
DEPTH, 8, number of table entries (power of 2)
ADDR_W, 3, log2(DEPTH)
DUR_WIDTH, 16, width of the per-step duration, in ticks
TICK_DIV, 131072, clock cycles per duration tick (>=2)
GAP_TICKS, 1, muted ticks between steps; 0 disables the gap

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
wr_en  in  1  table write strobe
wr_addr  in  ADDR_W  table write address
wr_freq  in  freq_width  frequency word to store
wr_sel  in  1  waveform select to store (1=sine, 0=cosine)
wr_dur  in  DUR_WIDTH  duration to store; 0 marks end of sequence
last_addr  in  ADDR_W  index of the final step
loop  in  1  1 = restart at step 0 after last_addr
start  in  1  single-cycle start pulse
stop  in  1  single-cycle abort pulse
freq  out  freq_width  frequency word to the CORDIC
waveform_sel  out  1  waveform select to the CORDIC
tone_en  out  1  1 while a step is sounding
busy  out  1  1 in any state other than IDLE
step  out  ADDR_W  index of the current entry
done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset, asynchronous, resetn=0:
  - State goes to IDLE.
  - All table entries clear to 0.
  - freq=0, waveform_sel=0, tone_en=0, busy=0, step=0, done=0.
  - Prescaler and duration counters clear to 0.
  - Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- Table writes:
  - A write takes effect at the clock edge and is accepted in any state.
  - The outputs of a step already playing do not change until the next FETCH.
  - If wr_en targets the address being read in the FETCH cycle, FETCH returns the new write data (bypass).
- States: IDLE, FETCH, PLAY, GAP.
- IDLE:
  - start=1 and stop=0: step<=0, go to FETCH.
  - start is ignored in every other state.
- FETCH (1 cycle):
  - Read entry[step].
  - If dur==0: pulse done, go to IDLE, tone_en stays 0.
  - Otherwise: load freq and waveform_sel, load the duration counter with dur, clear the prescaler, go to PLAY.
- PLAY:
  - tone_en=1.
  - The prescaler counts 0..TICK_DIV-1 and raises a tick when at TICK_DIV-1.
  - Each tick decrements the duration counter; the tick that takes it to 0 ends PLAY.
  - PLAY lasts exactly dur*TICK_DIV cycles.
  - At the end of PLAY: if GAP_TICKS>0 go to GAP (clear prescaler, load GAP_TICKS); otherwise take the advance rule.
- GAP:
  - tone_en=0; freq and waveform_sel hold their values.
  - Lasts GAP_TICKS*TICK_DIV cycles, then take the advance rule.
- Advance rule:
  - If step!=last_addr: step<=step+1, go to FETCH.
  - Else if loop=1: step<=0, go to FETCH.
  - Else: done=1 for one cycle, go to IDLE.
  - step wraps modulo DEPTH.
- stop:
  - Has priority over start and over every transition.
  - Next cycle: IDLE, tone_en=0, busy=0, done=0.
  - freq and waveform_sel hold their last values; step is unchanged.
- Latency: start asserted at edge N gives FETCH at N+1, then PLAY at N+2, where tone_en=1 and freq is valid.
- busy goes to 1 the cycle after start is accepted and drops together with done.
- last_addr and loop are sampled at each advance decision.

Test Plan:
1. Basic sequence, single pass
   - Stimulus: TICK_DIV=4, GAP_TICKS=1; entries {100,1,2}, {200,0,1}, {300,1,3}; last_addr=2, loop=0; pulse start.
   - Required: tone_en high 8 cycles at freq=100/sel=1, low 4 cycles, high 4 at 200/0, low 4, high 12 at 300/1, low 4; then a done pulse, busy=0, freq stays 300.
2. Loop with abort
   - Stimulus: same table, loop=1.
   - Required: after step 2, step=0 and freq=100 recurs.
   - Stimulus: pulse stop mid-PLAY.
   - Required: next cycle tone_en=0, busy=0, done never pulses.
3. End marker
   - Stimulus: entry1 dur=0, last_addr=2.
   - Required: after step 0 and its gap, the FETCH at step 1 pulses done; tone_en is never asserted for step 1.
4. Start/stop conflicts
   - Stimulus: start and stop in the same cycle from IDLE.
     Required: remain IDLE.
   - Stimulus: start pulse during PLAY.
     Required: no restart; the step count is unaffected.
5. Asynchronous reset
   - Stimulus: drop resetn between clock edges during PLAY.
   - Required: tone_en, busy and freq are 0 before the next edge.
   - After release: IDLE; a start with no new writes fetches dur=0 and pulses done.
6. Write bypass
   - Stimulus: write {555,0,1} to step 1 in its FETCH cycle.
     Required: PLAY uses freq=555.
   - Stimulus: write to step 0 during its own PLAY.
     Required: freq unchanged until the next loop FETCH.
